// File: rtl/vga_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fetch_pkg
//  Description : Shared fetch-state encoding and default video geometry for
//                the SDRAM line fetcher and the VGA timing block.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_REQ        = 3'd2,
    S_DATA       = 3'd3,
    S_LINE_END   = 3'd4
  } fetch_state_t;

  localparam int c_burst_len  = 8;
  localparam int c_line_words = 640;
  localparam int c_lines      = 480;
  localparam int c_fifo_depth = 256;

endpackage
`default_nettype wire

// File: rtl/line_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : line_addr_gen
//  Description : Burst address, line counter and per-line word budget for the
//                SDRAM line fetcher, driven by restart/line_start/advance/line_end.
//  Revision    : 1.0  initial release
// ============================================================================
module line_addr_gen
  import vga_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    BURST_LEN  = c_burst_len,
  parameter int                    LINE_WORDS = c_line_words,
  parameter int                    LINES      = c_lines,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  line_start,
  input  logic                  advance,
  input  logic                  line_end,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  last_burst
);

  localparam int c_wl_w = $clog2(LINE_WORDS + 1);
  localparam int c_lc_w = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [c_wl_w-1:0]     c_line_words_w = c_wl_w'(LINE_WORDS);
  localparam logic [c_wl_w-1:0]     c_burst_words  = c_wl_w'(BURST_LEN);
  localparam logic [c_lc_w-1:0]     c_last_line    = c_lc_w'(LINES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_step    = ADDR_WIDTH'(BURST_LEN);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_lc_w-1:0]     r_line_cnt;
  logic [c_wl_w-1:0]     r_words_left;

  // restart dominates; advance and line_end never coincide in the fetcher
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= FRAME_BASE;
      r_line_cnt   <= '0;
      r_words_left <= '0;
    end else if (restart) begin
      r_addr       <= FRAME_BASE;
      r_line_cnt   <= '0;
      r_words_left <= '0;
    end else begin
      if (line_start) begin
        r_words_left <= c_line_words_w;
      end
      if (advance) begin
        r_addr       <= r_addr + c_addr_step;
        r_words_left <= r_words_left - c_burst_words;
      end
      if (line_end) begin
        if (r_line_cnt == c_last_line) begin
          r_line_cnt <= '0;
          r_addr     <= FRAME_BASE;
        end else begin
          r_line_cnt <= r_line_cnt + 1'b1;
        end
      end
    end
  end

  assign rd_addr    = r_addr;
  assign last_burst = (r_words_left == c_burst_words);

endmodule
`default_nettype wire

// File: rtl/sdram_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_line_fetcher
//  Description : Fills the SDRAM->VGA line FIFO with fixed-length read bursts,
//                one outstanding at a time, gated on FIFO free space.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_line_fetcher
  import vga_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    BURST_LEN  = c_burst_len,
  parameter int                    LINE_WORDS = c_line_words,
  parameter int                    LINES      = c_lines,
  parameter int                    FIFO_DEPTH = c_fifo_depth,
  parameter int                    LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_req,
  input  logic [LVL_WIDTH-1:0]  fifo_level,
  input  logic                  fifo_full,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  line_done,
  output logic                  req_overrun,
  output logic                  protocol_err
);

  generate
    if ((LINE_WORDS % BURST_LEN) != 0) begin : g_bad_line_words
      $error("sdram_line_fetcher: LINE_WORDS must be a multiple of BURST_LEN");
    end
  endgenerate

  localparam int                   c_beat_w       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_beat_w-1:0]  c_last_beat    = c_beat_w'(BURST_LEN - 1);
  localparam logic [LVL_WIDTH-1:0] c_space_thresh = LVL_WIDTH'(FIFO_DEPTH - BURST_LEN);

  fetch_state_t          r_state, w_state_nxt;
  logic                  r_pending, w_pending_nxt;
  logic                  r_discard, w_discard_nxt;
  logic [c_beat_w-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic                  r_rd_req, w_rd_req_nxt;
  logic                  r_fifo_wr_en, w_fifo_wr_en_nxt;
  logic [DATA_WIDTH-1:0] r_fifo_wr_data, w_fifo_wr_data_nxt;
  logic                  r_line_done, w_line_done_nxt;
  logic                  r_req_overrun, w_req_overrun_nxt;
  logic                  r_protocol_err, w_protocol_err_nxt;
  logic                  w_restart, w_line_start, w_advance, w_line_end;
  logic                  w_last_burst;
  logic                  w_drop_beat;

  line_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES),
    .FRAME_BASE (FRAME_BASE)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .restart    (w_restart),
    .line_start (w_line_start),
    .advance    (w_advance),
    .line_end   (w_line_end),
    .rd_addr    (rd_addr),
    .last_burst (w_last_burst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pending      <= 1'b0;
      r_discard      <= 1'b0;
      r_beat_cnt     <= '0;
      r_rd_req       <= 1'b0;
      r_fifo_wr_en   <= 1'b0;
      r_fifo_wr_data <= '0;
      r_line_done    <= 1'b0;
      r_req_overrun  <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pending      <= w_pending_nxt;
      r_discard      <= w_discard_nxt;
      r_beat_cnt     <= w_beat_cnt_nxt;
      r_rd_req       <= w_rd_req_nxt;
      r_fifo_wr_en   <= w_fifo_wr_en_nxt;
      r_fifo_wr_data <= w_fifo_wr_data_nxt;
      r_line_done    <= w_line_done_nxt;
      r_req_overrun  <= w_req_overrun_nxt;
      r_protocol_err <= w_protocol_err_nxt;
    end
  end

  assign w_drop_beat = r_discard || frame_start;

  always_comb begin
    w_state_nxt        = r_state;
    w_pending_nxt      = r_pending;
    w_discard_nxt      = r_discard;
    w_beat_cnt_nxt     = r_beat_cnt;
    w_rd_req_nxt       = r_rd_req;
    w_fifo_wr_en_nxt   = 1'b0;
    w_fifo_wr_data_nxt = r_fifo_wr_data;
    w_line_done_nxt    = 1'b0;
    w_req_overrun_nxt  = r_req_overrun;
    w_protocol_err_nxt = r_protocol_err;
    w_restart          = 1'b0;
    w_line_start       = 1'b0;
    w_advance          = 1'b0;
    w_line_end         = 1'b0;

    // frame_start flushes any queued request, but a simultaneous line_req survives it
    if (frame_start) begin
      w_pending_nxt = line_req;
    end else if (line_req && (r_state != S_IDLE)) begin
      if (r_pending) w_req_overrun_nxt = 1'b1;
      else           w_pending_nxt     = 1'b1;
    end

    if ((rd_valid && (r_state != S_DATA)) || (r_fifo_wr_en && fifo_full)) begin
      w_protocol_err_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_restart = 1'b1;
        end else if (line_req || r_pending) begin
          w_pending_nxt = line_req && r_pending;
          w_line_start  = 1'b1;
          w_state_nxt   = S_WAIT_SPACE;
        end
      end

      S_WAIT_SPACE: begin
        if (frame_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (fifo_level <= c_space_thresh) begin
          w_rd_req_nxt = 1'b1;
          w_state_nxt  = S_REQ;
        end
      end

      S_REQ: begin
        // an acknowledged burst is already in flight, so it must drain even on frame_start
        if (rd_ack) begin
          w_rd_req_nxt   = 1'b0;
          w_beat_cnt_nxt = '0;
          w_discard_nxt  = frame_start;
          w_state_nxt    = S_DATA;
        end else if (frame_start) begin
          w_rd_req_nxt = 1'b0;
          w_restart    = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end

      S_DATA: begin
        if (frame_start) w_discard_nxt = 1'b1;
        if (rd_valid) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (!w_drop_beat) begin
            w_fifo_wr_en_nxt   = 1'b1;
            w_fifo_wr_data_nxt = rd_data;
          end
          if (r_beat_cnt == c_last_beat) begin
            if (w_drop_beat) begin
              w_discard_nxt = 1'b0;
              w_restart     = 1'b1;
              w_state_nxt   = S_IDLE;
            end else begin
              w_advance       = 1'b1;
              w_line_done_nxt = w_last_burst;
              w_state_nxt     = w_last_burst ? S_LINE_END : S_WAIT_SPACE;
            end
          end
        end
      end

      S_LINE_END: begin
        if (frame_start) w_restart  = 1'b1;
        else             w_line_end = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rd_req       = r_rd_req;
  assign fifo_wr_en   = r_fifo_wr_en;
  assign fifo_wr_data = r_fifo_wr_data;
  assign busy         = (r_state != S_IDLE);
  assign line_done    = r_line_done;
  assign req_overrun  = r_req_overrun;
  assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire
